// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller in front of the 4-bit 16-function ALU.
// Optional op_count output enabled by defining ALU_ISSUE_OPCNT_EN.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int RES_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    input  logic             req_shift,
    output logic             alu_A,
    output logic             alu_B,
    output logic             alu_C,
    output logic             alu_D,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_shiftCon,
    input  logic [RES_W-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic [3:0]       rsp_op,
`ifdef ALU_ISSUE_OPCNT_EN
    output logic             rsp_zero,
    output logic [15:0]      op_count
`else
    output logic             rsp_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_op       <= '0;
            rsp_zero     <= 1'b1;
            alu_A        <= 1'b0;
            alu_B        <= 1'b0;
            alu_C        <= 1'b0;
            alu_D        <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_shiftCon <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        {alu_A, alu_B, alu_C, alu_D} <= req_op;
                        alu_a        <= req_a;
                        alu_b        <= req_b;
                        alu_shiftCon <= req_shift;
                        cnt          <= CntInit;
                        req_ready    <= 1'b0;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // The held select lines are the op that made this result.
                        rsp_data  <= alu_res;
                        rsp_op    <= {alu_A, alu_B, alu_C, alu_D};
                        rsp_zero  <= (alu_res == '0);
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_OPCNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule
